// File: rtl/xcore_sched_pkg.sv
// Shared types and constants for the xcore scheduler.
// Build option: XCORE_SCHED_FIXED_PRIO_EN selects fixed-priority arbitration.
package xcore_sched_pkg;

  localparam int unsigned XS_OPW             = 6;
  localparam int unsigned XS_RESULT_WAIT_DEF = 16;
  localparam int unsigned XS_N_REQ_MAX       = 8;
  localparam int unsigned XS_IDW             = $clog2(XS_N_REQ_MAX);

  typedef enum logic [2:0] {
    INIT0,
    INIT1,
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } sched_state_t;

endpackage

// File: rtl/xcore_rr_arb.sv
// Requester arbiter: round-robin by default, fixed lowest-index priority
// when XCORE_SCHED_FIXED_PRIO_EN is defined.
module xcore_rr_arb
  import xcore_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant
);

`ifdef XCORE_SCHED_FIXED_PRIO_EN

  logic found;
  logic unused_ok;

  assign unused_ok = &{1'b0, clock, reset, advance};

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

`else

  logic [XS_IDW-1:0] ptr;
  logic [XS_IDW-1:0] win;
  logic              found;

  // Indices above the last winner are searched first, then wrap to 0..ptr.
  always_comb begin
    grant = '0;
    win   = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req[i] && (i > 32'(ptr))) begin
        grant[i] = 1'b1;
        win      = XS_IDW'(i);
        found    = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req[i] && (i <= 32'(ptr))) begin
        grant[i] = 1'b1;
        win      = XS_IDW'(i);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= XS_IDW'(N_REQ - 1);
    end else if (advance && found) begin
      ptr <= win;
    end
  end

`endif

endmodule

// File: rtl/xcore_sched.sv
// Schedules requester jobs onto one shared scrambler core and returns results.
// Build option: XCORE_SCHED_FIXED_PRIO_EN (fixed-priority arbitration).
module xcore_sched
  import xcore_sched_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned RESULT_WAIT = XS_RESULT_WAIT_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [XS_OPW*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    rsp_valid,
  output logic [XS_OPW-1:0]       rsp_data,
  output logic [2:0]              rsp_id,
  input  logic                    rsp_ready,
  output logic                    core_reset,
  output logic [XS_OPW-1:0]       core_x_in,
  output logic                    core_stbi,
  input  logic [XS_OPW-1:0]       core_x_out
);

  localparam int unsigned CW = $clog2(RESULT_WAIT) + 1;

  sched_state_t      state, state_nx;
  logic [CW-1:0]     wait_cnt;
  logic [XS_OPW-1:0] op_q;
  logic [2:0]        id_q;
  logic [N_REQ-1:0]  grant;
  logic              take;
  logic [2:0]        gidx;
  logic [XS_OPW-1:0] gdata;

  xcore_rr_arb #(
    .N_REQ(N_REQ)
  ) u_arb (
    .clock  (clock),
    .reset  (reset),
    .req    (req_valid),
    .advance(take),
    .grant  (grant)
  );

  always_comb begin
    gidx  = '0;
    gdata = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        gidx  = 3'(i);
        gdata = req_data[i*XS_OPW +: XS_OPW];
      end
    end
  end

  always_comb begin
    state_nx   = state;
    req_ready  = '0;
    take       = 1'b0;
    core_reset = 1'b0;
    core_stbi  = 1'b1;
    core_x_in  = '0;
    rsp_valid  = 1'b0;
    case (state)
      INIT0: begin
        core_reset = 1'b1;
        state_nx   = INIT1;
      end
      INIT1: state_nx = IDLE;
      IDLE: begin
        if (|req_valid) begin
          req_ready = grant;
          take      = 1'b1;
          state_nx  = LAUNCH;
        end
      end
      LAUNCH: begin
        core_stbi = 1'b0;
        core_x_in = op_q;
        state_nx  = WAIT;
      end
      WAIT: begin
        core_x_in = op_q;
        if (wait_cnt == CW'(RESULT_WAIT - 1)) state_nx = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = INIT0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= INIT0;
      wait_cnt <= '0;
      op_q     <= '0;
      id_q     <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        op_q <= gdata;
        id_q <= gidx;
      end
      if (state == LAUNCH) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      if (state == WAIT && state_nx == RESP) begin
        rsp_data <= core_x_out;
        rsp_id   <= id_q;
      end
    end
  end

endmodule

// File: tb/tb_xcore_sched.sv
// Self-checking bench for xcore_sched: job-timeline model plus directed scenarios.
`timescale 1ns/1ps
module tb_xcore_sched;

  localparam int N  = 4;
  localparam int RW = 16;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [6*N-1:0] req_data = '0;
  logic           rsp_ready = 1'b1;
  logic [5:0]     core_x_out = '0;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [5:0]     rsp_data;
  logic [2:0]     rsp_id;
  logic           core_reset;
  logic [5:0]     core_x_in;
  logic           core_stbi;

  xcore_sched #(
    .N_REQ(N),
    .RESULT_WAIT(RW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .core_reset(core_reset),
    .core_x_in (core_x_in),
    .core_stbi (core_stbi),
    .core_x_out(core_x_out)
  );

  always #5 clock = ~clock;

  // Core stub: output in cycle c is ((c-1)*5+3) mod 64.
  int cyc = 0;
  always @(posedge clock) begin
    cyc        <= cyc + 1;
    core_x_out <= 6'((cyc * 5 + 3) & 63);
  end

  function automatic int xo(int c);
    return ((c - 1) * 5 + 3) & 63;
  endfunction

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(logic [N-1:0] v, int ptr);
`ifdef XCORE_SCHED_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (v[k]) return k;
`else
    for (int k = 1; k <= N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
`endif
    return -1;
  endfunction

  // Model: one job at a time; grant g, launch g+1, result valid from g+RW+2.
  bit         armed = 0;
  int         m_i0 = 0;
  int         m_idle_from = 0;
  bit         m_job = 0;
  int         m_g = 0;
  int         m_id = 0;
  int         m_ptr = N - 1;
  logic [5:0] m_op = '0;
  logic [5:0] m_rsp_data = '0;
  int         m_rsp_id = 0;

  int         g_ids[$];
  int         g_cyc[$];
  int         r_ids[$];
  int         rv_rise[$];
  logic [5:0] r_data[$];
  logic [5:0] launch_x[$];
  int         n_crst = 0;
  int         n_stbi_low = 0;
  logic       prev_rv = 1'b0;

  always @(negedge clock) begin
    int  c;
    int  exp_g;
    bit  idle_now;
    c = cyc;
    if (armed && c >= m_i0) begin
      idle_now = !m_job && c >= m_idle_from;
      exp_g    = idle_now ? pick(req_valid, m_ptr) : -1;
      chk("req_ready", int'(req_ready), exp_g >= 0 ? (1 << exp_g) : 0);
      chk("core_reset", int'(core_reset), int'(c == m_i0));
      chk("core_stbi", int'(core_stbi), int'(!(m_job && c == m_g + 1)));
      chk("core_x_in", int'(core_x_in),
          (m_job && c >= m_g + 1 && c <= m_g + RW + 1) ? int'(m_op) : 0);
      chk("rsp_valid", int'(rsp_valid), int'(m_job && c >= m_g + RW + 2));
      chk("rsp_data", int'(rsp_data), int'(m_rsp_data));
      chk("rsp_id", int'(rsp_id), m_rsp_id);

      if (exp_g >= 0) begin
        m_job = 1; m_g = c; m_id = exp_g; m_ptr = exp_g;
        m_op  = req_data[exp_g*6 +: 6];
      end else if (m_job && c == m_g + RW + 1) begin
        m_rsp_data = core_x_out;
        m_rsp_id   = m_id;
      end else if (m_job && c >= m_g + RW + 2 && rsp_ready) begin
        m_job = 0;
        m_idle_from = c + 1;
      end

      for (int k = 0; k < N; k++) if (req_ready[k]) begin g_ids.push_back(k); g_cyc.push_back(c); end
      if (rsp_valid && !prev_rv) rv_rise.push_back(c);
      if (rsp_valid && rsp_ready) begin r_ids.push_back(int'(rsp_id)); r_data.push_back(rsp_data); end
      if (core_reset) n_crst++;
      if (!core_stbi) begin n_stbi_low++; launch_x.push_back(core_x_in); end
    end
    prev_rv = rsp_valid;
    if (reset) begin
      armed = 1; m_i0 = c + 1; m_idle_from = c + 3; m_job = 0; m_ptr = N - 1;
      m_rsp_data = '0; m_rsp_id = 0;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    g_ids.delete(); g_cyc.delete(); r_ids.delete(); rv_rise.delete();
    r_data.delete(); launch_x.delete(); n_crst = 0; n_stbi_low = 0;
  endtask

  task automatic wait_grants(int target, int budget);
    int k = 0;
    while (g_ids.size() < target && k < budget) begin tick(); k++; end
    chk("grant_timeout", int'(g_ids.size() >= target), 1);
  endtask

  task automatic wait_rsp(int target, int budget);
    int k = 0;
    while (r_ids.size() < target && k < budget) begin tick(); k++; end
    chk("rsp_timeout", int'(r_ids.size() >= target), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(2); reset = 1'b0;
  endtask

  initial begin
    int g;
    int r;
    int n2;
    int exp_order[8];

    // Reset then idle.
    do_reset();
    clear_logs();
    tick(4);
    chk("boot_core_reset_cycles", n_crst, 1);
    chk("boot_stbi_low", n_stbi_low, 0);
    chk("boot_grants", g_ids.size(), 0);

    // Single job from requester 0.
    clear_logs();
    req_data[5:0] = 6'h05; req_valid = 4'b0001;
    wait_grants(1, 50);
    req_valid = '0;
    wait_rsp(1, 60);
    if (g_ids.size() >= 1 && r_ids.size() >= 1 && rv_rise.size() >= 1) begin
      g = g_cyc[0];
      chk("single_grant_id", g_ids[0], 0);
      chk("single_rsp_latency", rv_rise[0] - g, RW + 2);
      chk("single_rsp_id", r_ids[0], 0);
      chk("single_rsp_data", int'(r_data[0]), xo(g + RW + 1));
    end
    chk("single_launch_cycles", n_stbi_low, 1);
    if (launch_x.size() >= 1) chk("single_launch_x", int'(launch_x[0]), 5);

    // All requesters held for 8 jobs.
    do_reset();
    clear_logs();
    req_data  = {6'h34, 6'h23, 6'h12, 6'h01};
    req_valid = 4'b1111;
    wait_grants(8, 8 * (RW + 3) + 40);
    req_valid = '0;
    wait_rsp(8, 60);
`ifdef XCORE_SCHED_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    for (int i = 0; i < 8; i++)
      if (i < g_ids.size()) chk($sformatf("order_%0d", i), g_ids[i], exp_order[i]);
    if (g_cyc.size() >= 2) chk("b2b_spacing", g_cyc[1] - g_cyc[0], RW + 3);

    // Consumer stall during RESP.
    clear_logs();
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    wait_grants(1, 50);
    req_valid = '0;
    begin
      int k = 0;
      while (rv_rise.size() < 1 && k < 60) begin tick(); k++; end
      chk("stall_rsp_timeout", int'(rv_rise.size() >= 1), 1);
    end
    req_valid = 4'b1000;
    tick(10);
    chk("stall_no_grant", g_ids.size(), 1);
    r = cyc;
    rsp_ready = 1'b1;
    wait_grants(2, 10);
    req_valid = '0;
    if (g_ids.size() >= 2) begin
      chk("stall_next_grant_delay", g_cyc[1] - r, 1);
      chk("stall_next_grant_id", g_ids[1], 3);
    end
    wait_rsp(2, 60);
    if (r_ids.size() >= 1) chk("stall_rsp_id", r_ids[0], 1);

    // Reset during WAIT drops the job.
    tick(3);
    clear_logs();
    req_data[5:0] = 6'h2A; req_valid = 4'b0001;
    wait_grants(1, 50);
    req_valid = '0;
    tick(5);
    reset = 1'b1; tick(); reset = 1'b0;
    n_crst = 0;
    tick(RW + 8);
    chk("abort_no_rsp", rv_rise.size(), 0);
    chk("abort_reinit", n_crst, 1);
    req_data[11:6] = 6'h11; req_valid = 4'b0010;
    wait_grants(2, 50);
    req_valid = '0;
    wait_rsp(1, 60);
    if (g_ids.size() >= 2 && r_ids.size() >= 1) begin
      chk("after_abort_id", r_ids[0], 1);
      chk("after_abort_data", int'(r_data[0]), xo(g_cyc[1] + RW + 1));
    end

    // Short request pulse while busy is never served.
    tick(3);
    clear_logs();
    req_data[5:0] = 6'h3C; req_valid = 4'b0001;
    wait_grants(1, 50);
    req_valid = '0;
    tick(4);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    wait_rsp(1, 60);
    tick(30);
    n2 = 0;
    foreach (r_ids[i]) if (r_ids[i] == 2) n2++;
    chk("pulse_no_rsp_id2", n2, 0);
    chk("pulse_grants", g_ids.size(), 1);
    if (r_ids.size() >= 1) chk("pulse_rsp_id", r_ids[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
